// File: rtl/branch_trace_player.sv
// Replays a buffered branch trace into a predictor, counts misses and divides out the miss-rate percentage.
// Optional build macro TRACE_SENTINEL_EN: an all-ones record in the buffer ends the replay early.
module branch_trace_player #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [35:0]   wr_data,
  input  logic [AW:0]   trace_len,
  input  logic          start,
  input  logic          miss,
  output logic [31:0]   b_add,
  output logic          outcome,
  output logic          rec_valid,
  output logic          pred_rst,
  output logic          busy,
  output logic          done,
  output logic [31:0]   miss_count,
  output logic [31:0]   branch_count,
  output logic [6:0]    miss_rate
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW:0] DepthL = DEPTH[AW:0];

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [31:0]   miss_cnt_q, miss_cnt_d;
  logic [31:0]   br_cnt_q, br_cnt_d;
  logic [6:0]    rate_q, rate_d;
  logic          pred_rst_q, pred_rst_d;
  logic [31:0]   num_q, num_d;
  logic [31:0]   den_q, den_d;
  logic [32:0]   rem_q, rem_d;
  logic [31:0]   quot_q, quot_d;
  logic [4:0]    step_q, step_d;

  logic [35:0]   mem_q [DEPTH];
  logic [35:0]   rec;
  logic          is_end;
  logic          drive;
  logic          rec_unused;

  logic          idle_like;
  logic [31:0]   mc_fin, bc_fin;
  logic [32:0]   rem_shift;
  logic          qbit;
  logic [31:0]   quot_next;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

  // Trace buffer has no reset so a loaded trace survives an aborted run.
  always_ff @(posedge clk) begin
    if (reset && wr_en && idle_like) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rec        = mem_q[idx_q];
  assign rec_unused = ^rec[3:1];

`ifdef TRACE_SENTINEL_EN
  assign is_end = (rec == 36'hFFFFFFFFF);
`else
  assign is_end = 1'b0;
`endif

  assign drive        = (state_q == S_RUN) && !is_end;
  assign rec_valid    = drive;
  assign b_add        = drive ? rec[35:4] : 32'd0;
  assign outcome      = drive ? rec[0] : 1'b0;
  assign pred_rst     = pred_rst_q;
  assign busy         = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_DIV);
  assign done         = (state_q == S_DONE);
  assign miss_count   = miss_cnt_q;
  assign branch_count = br_cnt_q;
  assign miss_rate    = rate_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    miss_cnt_d = miss_cnt_q;
    br_cnt_d   = br_cnt_q;
    rate_d     = rate_q;
    pred_rst_d = 1'b0;
    num_d      = num_q;
    den_d      = den_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    step_d     = step_q;
    mc_fin     = miss_cnt_q;
    bc_fin     = br_cnt_q;
    rem_shift  = 33'd0;
    qbit       = 1'b0;
    quot_next  = quot_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && (trace_len != '0)) begin
          state_d    = S_LAUNCH;
          idx_d      = '0;
          miss_cnt_d = 32'd0;
          br_cnt_d   = 32'd0;
          rate_d     = 7'd0;
          pred_rst_d = 1'b1;
          len_d      = (trace_len > DepthL) ? DepthL : trace_len;
        end
      end

      // One cycle with the predictor held in reset before the first record.
      S_LAUNCH: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (!is_end) begin
          mc_fin     = miss_cnt_q + {31'd0, miss};
          bc_fin     = br_cnt_q + 32'd1;
          miss_cnt_d = mc_fin;
          br_cnt_d   = bc_fin;
        end
        if (is_end || ({1'b0, idx_q} == (len_q - 1'b1))) begin
          state_d = S_DIV;
          num_d   = (mc_fin * 32'd100) + (bc_fin >> 1);
          den_d   = bc_fin;
          rem_d   = 33'd0;
          quot_d  = 32'd0;
          step_d  = 5'd0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      // Restoring divide, one quotient bit per cycle; the half-divisor bias rounds to nearest.
      S_DIV: begin
        if (den_q == 32'd0) begin
          rate_d  = 7'd0;
          state_d = S_DONE;
        end else begin
          rem_shift = {rem_q[31:0], num_q[31]};
          if (rem_shift >= {1'b0, den_q}) begin
            rem_d = rem_shift - {1'b0, den_q};
            qbit  = 1'b1;
          end else begin
            rem_d = rem_shift;
          end
          quot_next = {quot_q[30:0], qbit};
          quot_d    = quot_next;
          num_d     = {num_q[30:0], 1'b0};
          step_d    = step_q + 5'd1;
          if (step_q == 5'd31) begin
            rate_d  = quot_next[6:0];
            state_d = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      miss_cnt_q <= 32'd0;
      br_cnt_q   <= 32'd0;
      rate_q     <= 7'd0;
      pred_rst_q <= 1'b1;
      num_q      <= 32'd0;
      den_q      <= 32'd0;
      rem_q      <= 33'd0;
      quot_q     <= 32'd0;
      step_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      miss_cnt_q <= miss_cnt_d;
      br_cnt_q   <= br_cnt_d;
      rate_q     <= rate_d;
      pred_rst_q <= pred_rst_d;
      num_q      <= num_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      step_q     <= step_d;
    end
  end

endmodule

// File: tb/tb_branch_trace_player.sv
// Scoreboard bench for branch_trace_player: directed traces, expected results queued at start, checked when done rises.
module tb_branch_trace_player;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [35:0]   wr_data;
  logic [AW:0]   trace_len;
  logic          start;
  logic          miss;
  logic [31:0]   b_add;
  logic          outcome;
  logic          rec_valid;
  logic          pred_rst;
  logic          busy;
  logic          done;
  logic [31:0]   miss_count;
  logic [31:0]   branch_count;
  logic [6:0]    miss_rate;

  typedef struct {
    int bc;
    int mc;
    int rate;
    int lat;
    int e0;
  } exp_t;

  exp_t        sbQ[$];
  logic [35:0] shadow [DEPTH];
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          missMode = 0;
  int          missK = 0;
  int          missIdx = 0;
  logic        prevOutcome = 1'b0;
  logic        prevDone = 1'b0;

  branch_trace_player #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .trace_len(trace_len),
    .start(start),
    .miss(miss),
    .b_add(b_add),
    .outcome(outcome),
    .rec_valid(rec_valid),
    .pred_rst(pred_rst),
    .busy(busy),
    .done(done),
    .miss_count(miss_count),
    .branch_count(branch_count),
    .miss_rate(miss_rate)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Predictor stand-in: tracks which record is live and the previous outcome.
  always @(posedge clk) begin
    if (pred_rst) begin
      missIdx     <= 0;
      prevOutcome <= 1'b0;
    end else if (rec_valid) begin
      missIdx     <= missIdx + 1;
      prevOutcome <= outcome;
    end
  end

  always_comb begin
    miss = 1'b0;
    case (missMode)
      1: miss = rec_valid;
      2: miss = rec_valid & (outcome ^ prevOutcome);
      3: miss = rec_valid && (missIdx < missK);
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Monitor: checks every live record against the shadow copy and pops the scoreboard when done rises.
  always @(negedge clk) begin
    exp_t e;
    if (rec_valid && missIdx < DEPTH) begin
      checkOutput("b_add", b_add, shadow[missIdx][35:4]);
      checkOutput("outcome", 32'(outcome), 32'(shadow[missIdx][0]));
    end
    if (done && !prevDone) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("branch_count", branch_count, e.bc);
        checkOutput("miss_count", miss_count, e.mc);
        checkOutput("miss_rate", 32'(miss_rate), e.rate);
        checkOutput("done_latency", cycle - e.e0, e.lat);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end
    prevDone = done;
  end

  task automatic writeRec(input int a, input logic [35:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    shadow[a] = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input int mode, input int k, input bit expectDone,
                               input int expBc, input int expMc, input int expRate, input int expLat);
    exp_t e;
    missMode  = mode;
    missK     = k;
    trace_len = (AW+1)'(len);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.bc = expBc;
    e.mc = expMc;
    e.rate = expRate;
    e.lat = expLat;
    e.e0 = cycle;
    if (expectDone) sbQ.push_back(e);
    checkOutput("pred_rst_launch", 32'(pred_rst), 32'd1);
    checkOutput("done_cleared", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("pred_rst_drop", 32'(pred_rst), 32'd0);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200; i++) begin
      if (sbQ.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got pending=%0d expected pending=0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rec_valid", 32'(rec_valid), 32'd0);
    checkOutput("rst_b_add", b_add, 32'd0);
    checkOutput("rst_outcome", 32'(outcome), 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);
    checkOutput("rst_branch_count", branch_count, 32'd0);
    checkOutput("rst_miss_rate", 32'(miss_rate), 32'd0);
    checkOutput("rst_pred_rst", 32'(pred_rst), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [3:0] pat;
    pat       = 4'b1011;
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    trace_len = '0;
    start     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pred_rst_release", 32'(pred_rst), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      logic ob;
      ob = (i < 4) ? pat[i] : i[0];
      writeRec(i, {32'hA000_0000 + 32'(i) * 32'h10, 3'b000, ob});
    end

    $display("[TB] xor-miss trace, 4 records");
    applyStimulus(4, 2, 0, 1'b1, 4, 3, 75, 37);
    waitDone();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_rate", 32'(miss_rate), 32'd75);

    $display("[TB] rounding cases, 3 records");
    applyStimulus(3, 3, 1, 1'b1, 3, 1, 33, 36);
    waitDone();
    applyStimulus(3, 3, 2, 1'b1, 3, 2, 67, 36);
    waitDone();

    $display("[TB] clamped length, no misses");
    applyStimulus(40, 0, 0, 1'b1, 32, 0, 0, 65);
    waitDone();

    trace_len = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("zero_len_busy", 32'(busy), 32'd0);
    checkOutput("zero_len_done", 32'(done), 32'd1);

    $display("[TB] all misses with start/write pulsed mid-run");
    applyStimulus(32, 1, 0, 1'b1, 32, 32, 100, 65);
    repeat (8) @(posedge clk);
    #1;
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = AW'(20);
    wr_data = 36'h123456789;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    waitDone();
    applyStimulus(24, 0, 0, 1'b1, 24, 0, 0, 57);
    waitDone();

    $display("[TB] reset during divide");
    applyStimulus(4, 1, 0, 1'b0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("div_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs();
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("aborted_done", 32'(done), 32'd0);

    applyStimulus(4, 2, 0, 1'b1, 4, 3, 75, 37);
    waitDone();

`ifdef TRACE_SENTINEL_EN
    $display("[TB] sentinel records");
    writeRec(5, 36'hFFFFFFFFF);
    applyStimulus(32, 1, 0, 1'b1, 5, 5, 100, 39);
    waitDone();
    writeRec(0, 36'hFFFFFFFFF);
    applyStimulus(32, 1, 0, 1'b1, 0, 0, 0, 3);
    waitDone();
`else
    $display("[TB] all-ones record is an ordinary branch");
    writeRec(5, 36'hFFFFFFFFF);
    applyStimulus(8, 1, 0, 1'b1, 8, 8, 100, 41);
    waitDone();
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
